serial_tx_queue: RTL and testbench

SERIAL_TX_QUEUE -- requirements
Module: serial_tx_queue

---
 rtl/serial_tx_queue.sv | 209 ++++++++++++++++++++
 tb/tb_serial_tx_queue.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// serial_tx_queue : FIFO-buffered asynchronous serial transmitter (start/data/
//                   optional parity/stop). Optional flow control: define
//                   SERIAL_TX_FLOW_CONTROL_EN to gate sends on peer_cts_n.
// Revision: 1.0
// ----------------------------------------------------------------------------
module serial_tx_queue #(
  parameter int CLK_FREQUENCY_HZ = 108_000_000,
  parameter int SERIAL_BPS       = 3_000_000,
  parameter int DATA_BITS        = 8,
  parameter int FIFO_DEPTH       = 16,
  parameter int PARITY           = 0,
  parameter int STOP_BITS        = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_data_available,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  input  logic                          peer_cts_n,
  output logic                          tx,
  output logic                          sending
);

  localparam int c_divisor  = CLK_FREQUENCY_HZ / SERIAL_BPS;
  localparam int c_addr_w   = $clog2(FIFO_DEPTH);
  localparam int c_stop_len = STOP_BITS * c_divisor;
  localparam int c_cnt_w    = $clog2(c_stop_len);
  localparam int c_idx_w    = $clog2(DATA_BITS);

  localparam logic [c_addr_w:0]  c_full_level = (c_addr_w + 1)'(FIFO_DEPTH);
  localparam logic [c_cnt_w-1:0] c_bit_last   = c_cnt_w'(c_divisor - 1);
  localparam logic [c_cnt_w-1:0] c_stop_last  = c_cnt_w'(c_stop_len - 1);
  localparam logic [c_idx_w-1:0] c_idx_last   = c_idx_w'(DATA_BITS - 1);

  generate
    if (c_divisor < 2) begin : g_bad_divisor
      $error("serial_tx_queue: CLK_FREQUENCY_HZ / SERIAL_BPS must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 || FIFO_DEPTH > 256 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
      $error("serial_tx_queue: parameter out of legal range");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [c_addr_w-1:0]  r_wr_ptr;
  logic [c_addr_w-1:0]  r_rd_ptr;
  logic [c_addr_w:0]    r_level;
  logic                 r_overflow;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_idx_w-1:0]   r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;
  logic                 r_tx;
  logic                 r_sending;

  logic w_send_ok;
  logic w_wr_accept;
  logic w_pop;

`ifdef SERIAL_TX_FLOW_CONTROL_EN
  // Reset to "not clear" so nothing leaves before peer_cts_n has been sampled twice.
  logic [1:0] r_cts_sync;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cts_sync <= 2'b11;
    end else begin
      r_cts_sync <= {r_cts_sync[0], peer_cts_n};
    end
  end
  assign w_send_ok = ~r_cts_sync[1];
`else
  logic w_unused_cts;
  assign w_unused_cts = peer_cts_n;
  assign w_send_ok    = 1'b1;
`endif

  assign full        = (r_level == c_full_level);
  assign level       = r_level;
  assign overflow    = r_overflow;
  assign tx          = r_tx;
  assign sending     = r_sending;
  assign w_wr_accept = in_data_available && !full;
  assign w_pop       = (r_state == S_IDLE) && (r_level != '0) && w_send_ok;

  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= in_data_available && full;
      if (w_wr_accept) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr_accept, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // tx/sending are registered and updated on each state transition, so they
  // always reflect the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_tx      <= 1'b1;
      r_sending <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift   <= r_mem[r_rd_ptr];
            r_parity  <= (^r_mem[r_rd_ptr]) ^ (PARITY == 1);
            r_cnt     <= '0;
            r_tx      <= 1'b0;
            r_sending <= 1'b1;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (r_cnt == c_bit_last) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == c_bit_last) begin
            r_cnt <= '0;
            if (r_idx != c_idx_last) begin
              r_idx   <= r_idx + 1'b1;
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1;
            end else if (PARITY != 0) begin
              r_tx    <= r_parity;
              r_state <= S_PARITY;
            end else begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (r_cnt == c_bit_last) begin
            r_cnt   <= '0;
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_cnt == c_stop_last) begin
            r_cnt     <= '0;
            r_sending <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_tx      <= 1'b1;
          r_sending <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_queue.sv
`default_nettype none
// tb_serial_tx_queue: randomized bench comparing line waveforms against a
// frame-level reference model (slot list expanded by the bit period).
module tb_serial_tx_queue;

  localparam int DIV   = 108_000_000 / 3_000_000;
  localparam int DEPTH = 16;
  localparam int LEN_D = 10 * DIV;
  localparam int LEN_P = 12 * DIV;
  localparam int MAXS  = LEN_P + 2;
`ifdef SERIAL_TX_FLOW_CONTROL_EN
  localparam int FC = 1;
`else
  localparam int FC = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       peer_cts_n = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_av = 1'b0;
  logic       full, overflow, tx, sending;
  logic [4:0] level;
  logic [7:0] in_data_p = '0;
  logic       in_av_p = 1'b0;
  logic       full_p, overflow_p, tx_p, sending_p;
  logic [4:0] level_p;

  int   tests_run = 0;
  int   tests_failed = 0;
  logic cap_tx  [MAXS];
  logic cap_snd [MAXS];
  int   cap_level;
  int   cap_wait;
  bit   cap_found;

  serial_tx_queue dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_data_available(in_av),
    .full(full), .level(level), .overflow(overflow), .peer_cts_n(peer_cts_n),
    .tx(tx), .sending(sending));

  serial_tx_queue #(.PARITY(2), .STOP_BITS(2)) dut_p (
    .clk(clk), .reset_n(reset_n), .in_data(in_data_p), .in_data_available(in_av_p),
    .full(full_p), .level(level_p), .overflow(overflow_p), .peer_cts_n(peer_cts_n),
    .tx(tx_p), .sending(sending_p));

  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", tests_run);
    $fatal(1, "watchdog expired");
  end

  // Reference line value of frame slot 'slot': start, LSB-first data, parity, stop(s).
  function automatic logic slot_bit(input logic [7:0] d, input int par, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return d[slot-1];
    if (par != 0 && slot == 9) return (par == 2) ? (^d) : ~(^d);
    return 1'b1;
  endfunction

  function automatic int frame_errors(input logic [7:0] d, input int par, input int len);
    int e = 0;
    for (int i = 0; i < len; i++)
      if (cap_tx[i] !== slot_bit(d, par, i / DIV) || cap_snd[i] !== 1'b1) e++;
    return e;
  endfunction

  // Waits (at negedges) for a start bit, then records len+2 line samples.
  task automatic capture(input bit use_p, input int len, input int timeout);
    cap_found = 0;
    cap_wait  = 0;
    while (!cap_found && cap_wait <= timeout) begin
      if ((use_p ? tx_p : tx) === 1'b0) cap_found = 1;
      else begin cap_wait++; @(negedge clk); end
    end
    if (cap_found) begin
      cap_level = use_p ? int'(level_p) : int'(level);
      for (int i = 0; i < len + 2; i++) begin
        if (i > 0) @(negedge clk);
        cap_tx[i]  = use_p ? tx_p : tx;
        cap_snd[i] = use_p ? sending_p : sending;
      end
    end
  endtask

  task automatic do_reset;
    @(negedge clk); reset_n = 1'b0; in_av = 1'b0; in_av_p = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1; peer_cts_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0; peer_cts_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++; if (tx !== 1'b1) begin tests_failed++; $display("FAIL reset_tx: got %b expected 1", tx); end
    tests_run++; if (sending !== 1'b0) begin tests_failed++; $display("FAIL reset_sending: got %b expected 0", sending); end
    tests_run++; if (full !== 1'b0) begin tests_failed++; $display("FAIL reset_full: got %b expected 0", full); end
    tests_run++; if (level !== 5'd0) begin tests_failed++; $display("FAIL reset_level: got %0d expected 0", level); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    tests_run++; if (tx_p !== 1'b1 || sending_p !== 1'b0) begin tests_failed++; $display("FAIL reset_par_inst: got tx=%b sending=%b expected 1/0", tx_p, sending_p); end
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_frame;
    int errs;
    @(negedge clk); in_data = 8'h41; in_av = 1'b1;
    @(negedge clk); in_av = 1'b0;
    tests_run++; if (level !== 5'd1) begin tests_failed++; $display("FAIL single_level_after_write: got %0d expected 1", level); end
    capture(0, LEN_D, 20);
    tests_run++; if (!cap_found || cap_wait != 1) begin tests_failed++; $display("FAIL single_start_latency: got found=%0d wait=%0d expected found=1 wait=1", cap_found, cap_wait); end
    if (cap_found) begin
      errs = frame_errors(8'h41, 0, LEN_D);
      tests_run++; if (errs !== 0) begin tests_failed++; $display("FAIL single_frame_wave: got %0d bad samples expected 0", errs); end
      tests_run++; if (cap_tx[LEN_D] !== 1'b1 || cap_snd[LEN_D] !== 1'b0) begin tests_failed++; $display("FAIL single_end: got tx=%b sending=%b expected 1/0", cap_tx[LEN_D], cap_snd[LEN_D]); end
      tests_run++; if (cap_level !== 0) begin tests_failed++; $display("FAIL single_level_at_start: got %0d expected 0", cap_level); end
    end
  endtask

  // Back-to-back writes; frames must follow each other with one idle cycle.
  task automatic test_burst(input bit use_p, input int n, input logic [7:0] b0, input logic [7:0] b1);
    logic [7:0] q[$];
    logic [7:0] d;
    int par, len, errs;
    par = use_p ? 2 : 0;
    len = use_p ? LEN_P : LEN_D;
    q.push_back(b0);
    q.push_back(b1);
    for (int i = 2; i < n; i++) q.push_back(8'($urandom));
    fork
      begin
        for (int i = 0; i < n; i++) begin
          @(negedge clk);
          if (use_p) begin in_data_p = q[i]; in_av_p = 1'b1; end
          else begin in_data = q[i]; in_av = 1'b1; end
        end
        @(negedge clk); in_av = 1'b0; in_av_p = 1'b0;
      end
      begin
        for (int k = 0; k < n; k++) begin
          capture(use_p, len, 60);
          d = q.pop_front();
          errs = cap_found ? frame_errors(d, par, len) : -1;
          tests_run++; if (errs !== 0) begin tests_failed++; $display("FAIL burst_frame_wave[%0d]: got %0d bad samples (data %h) expected 0", k, errs, d); end
          if (!cap_found) break;
          tests_run++;
          if (cap_tx[len] !== 1'b1 || cap_snd[len] !== 1'b0 || cap_tx[len+1] !== ((q.size() > 0) ? 1'b0 : 1'b1)) begin
            tests_failed++; $display("FAIL burst_gap[%0d]: got tx=%b,%b sending=%b expected 1,%b,0", k, cap_tx[len], cap_tx[len+1], cap_snd[len], (q.size() > 0) ? 1'b0 : 1'b1);
          end
          if (k > 0) begin
            tests_run++; if (cap_level !== q.size()) begin tests_failed++; $display("FAIL burst_level[%0d]: got %0d expected %0d", k, cap_level, q.size()); end
          end
          if (use_p && k == 0) begin
            tests_run++; if (cap_tx[9*DIV] !== (^b0)) begin tests_failed++; $display("FAIL burst_parity_bit: got %b expected %b", cap_tx[9*DIV], ^b0); end
          end
        end
      end
    join
    tests_run++; if ((use_p ? level_p : level) !== 5'd0) begin tests_failed++; $display("FAIL burst_level_end: got %0d expected 0", use_p ? level_p : level); end
  endtask

  task automatic test_overflow;
    int n, ovf_cnt, ovf_at, full_at, tx_low;
    n = DEPTH + 1 + (1 - FC);
    ovf_cnt = 0; ovf_at = -1; full_at = -1; tx_low = 0;
    peer_cts_n = (FC != 0);
    repeat (4) @(negedge clk);
    for (int i = 0; i < n + 3; i++) begin
      @(negedge clk);
      if (overflow === 1'b1) begin ovf_cnt++; if (ovf_at < 0) ovf_at = i; end
      if (full === 1'b1 && full_at < 0) full_at = i;
      if (tx !== 1'b1) tx_low++;
      if (i < n) begin in_data = 8'($urandom); in_av = 1'b1; end
      else in_av = 1'b0;
    end
    tests_run++; if (full_at !== DEPTH + (1 - FC)) begin tests_failed++; $display("FAIL ovf_full_after_write: got %0d expected %0d", full_at, DEPTH + (1 - FC)); end
    tests_run++; if (ovf_cnt !== 1 || ovf_at !== n) begin tests_failed++; $display("FAIL ovf_pulse: got count=%0d at=%0d expected count=1 at=%0d", ovf_cnt, ovf_at, n); end
    tests_run++; if (level !== 5'd16 || full !== 1'b1) begin tests_failed++; $display("FAIL ovf_level: got level=%0d full=%b expected 16/1", level, full); end
`ifdef SERIAL_TX_FLOW_CONTROL_EN
    tests_run++; if (tx_low !== 0) begin tests_failed++; $display("FAIL ovf_tx_held: got %0d low samples expected 0", tx_low); end
`endif
    peer_cts_n = 1'b0;
  endtask

  task automatic test_reset_midframe;
    int w, bad;
    @(negedge clk); in_data = 8'($urandom); in_av = 1'b1;
    @(negedge clk); in_data = 8'($urandom);
    @(negedge clk); in_av = 1'b0;
    w = 0;
    while (tx !== 1'b0 && w < 20) begin @(negedge clk); w++; end
    tests_run++; if (tx !== 1'b0) begin tests_failed++; $display("FAIL mid_start: got tx=%b expected 0", tx); end
    repeat (99) @(negedge clk);
    tests_run++; if (sending !== 1'b1 || level !== 5'd1) begin tests_failed++; $display("FAIL mid_before_reset: got sending=%b level=%0d expected 1/1", sending, level); end
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if (tx !== 1'b1 || sending !== 1'b0 || level !== 5'd0 || full !== 1'b0) begin
      tests_failed++; $display("FAIL mid_async_reset: got tx=%b sending=%b level=%0d full=%b expected 1/0/0/0", tx, sending, level, full);
    end
    @(negedge clk); @(negedge clk); reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || sending !== 1'b0) bad++;
    end
    tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL mid_no_residual: got %0d active samples expected 0", bad); end
  endtask

  task automatic test_cts;
    int errs;
    peer_cts_n = 1'b1;
    repeat (4) @(negedge clk);
    @(negedge clk); in_data = 8'h30; in_av = 1'b1;
    @(negedge clk); in_av = 1'b0;
`ifdef SERIAL_TX_FLOW_CONTROL_EN
    errs = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) errs++;
    end
    tests_run++; if (errs !== 0 || level !== 5'd1) begin tests_failed++; $display("FAIL cts_blocked: got %0d low samples level=%0d expected 0/1", errs, level); end
    peer_cts_n = 1'b0;
    capture(0, LEN_D, 10);
    tests_run++; if (!cap_found || cap_wait < 2) begin tests_failed++; $display("FAIL cts_release: got found=%0d wait=%0d expected found=1 wait>=2", cap_found, cap_wait); end
`else
    capture(0, LEN_D, 10);
    tests_run++; if (!cap_found || cap_wait != 1) begin tests_failed++; $display("FAIL cts_ignored_start: got found=%0d wait=%0d expected found=1 wait=1", cap_found, cap_wait); end
`endif
    errs = cap_found ? frame_errors(8'h30, 0, LEN_D) : -1;
    tests_run++; if (errs !== 0) begin tests_failed++; $display("FAIL cts_frame_wave: got %0d bad samples expected 0", errs); end
    peer_cts_n = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_burst(1'b0, 2, 8'h55, 8'hAA);
    test_burst(1'b0, int'($urandom_range(3, 6)), 8'($urandom), 8'($urandom));
    test_burst(1'b1, 3, 8'h07, 8'($urandom));
    test_overflow;
    do_reset;
    test_reset_midframe;
    test_cts;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
